instr_trace_buffer: RTL and testbench

- Parametrised on-chip instruction trace recorder for the CPU debug and bench environment.
- Snoops retired instructions (pc + 32-bit word) into a circular buffer.
- Freezes the buffer on a programmable opcode/field match, a HALT, or after a post-trigger count.
- Replays captured entries oldest-first over a valid/ready port for the UART dump logic or the testbench display.

---
 rtl/instr_trace_buffer.sv | 153 +++++++++++++++
 tb/tb_instr_trace_buffer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_trace_buffer.sv
// Instruction trace recorder: snoops retired instructions into a circular buffer,
// freezes on trigger/HALT/post-count, then replays entries oldest-first.
module instr_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       arm,
  input  logic                       clear,
  input  logic [31:0]                trig_mask,
  input  logic [31:0]                trig_value,
  input  logic [$clog2(DEPTH):0]     post_count,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic                       halt_seen,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [PC_W-1:0]            rd_pc,
  output logic [31:0]                rd_instr,
  output logic [TS_W-1:0]            rd_delta,
  output logic                       rd_last
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PC_W + 32 + TS_W;
  localparam logic [7:0]  OP_HALT = 8'h09;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fill_q;
  logic [CW-1:0]   pc_lat;
  logic [CW-1:0]   pc_clamp;
  logic [CW-1:0]   remaining;
  logic [CW-1:0]   rd_idx;
  logic [TS_W-1:0] dcnt;
  logic            trig_q;
  logic            halt_q;
  logic            capture;
  logic            match;
  logic            is_halt;
  logic            xfer;
  logic [EW-1:0]   rd_word;

  assign capture  = in_valid && (state_q == S_ARMED || state_q == S_POST);
  assign match    = (in_instr & trig_mask) == (trig_value & trig_mask);
  assign is_halt  = in_instr[7:0] == OP_HALT;
  assign pc_clamp = (post_count == '0) ? CW'(1) :
                    (post_count > CW'(DEPTH)) ? CW'(DEPTH) : post_count;

  // Readout walks from the oldest surviving entry; fill==DEPTH starts at wr_ptr.
  assign rd_ptr   = wr_ptr - AW'(fill_q) + AW'(rd_idx);
  assign rd_word  = mem[rd_ptr];
  assign rd_valid = (state_q == S_DONE) && (rd_idx < fill_q);
  assign rd_last  = rd_valid && ((fill_q - rd_idx) == CW'(1));
  assign xfer     = rd_valid && rd_ready;
  assign rd_pc    = rd_valid ? rd_word[EW-1 -: PC_W] : '0;
  assign rd_instr = rd_valid ? rd_word[TS_W +: 32]   : '0;
  assign rd_delta = rd_valid ? rd_word[TS_W-1:0]     : '0;

  assign state     = state_q;
  assign triggered = trig_q;
  assign halt_seen = halt_q;
  assign fill      = fill_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: if (capture && (match || is_halt))
                 state_d = (pc_lat == CW'(1) || is_halt) ? S_DONE : S_POST;
      S_POST:  if (capture && (is_halt || remaining == CW'(1))) state_d = S_DONE;
      S_DONE:  if (xfer && rd_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // First entry of a capture always records a zero delta.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {in_pc, in_instr, (fill_q == '0) ? TS_W'(0) : dcnt};
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      fill_q    <= '0;
      rd_idx    <= '0;
      dcnt      <= '0;
      trig_q    <= 1'b0;
      halt_q    <= 1'b0;
      pc_lat    <= CW'(1);
      remaining <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (arm) begin
          wr_ptr <= '0;
          fill_q <= '0;
          rd_idx <= '0;
          dcnt   <= '0;
          trig_q <= 1'b0;
          halt_q <= 1'b0;
          pc_lat <= pc_clamp;
        end
        S_ARMED, S_POST: begin
          if (capture) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (fill_q != CW'(DEPTH)) fill_q <= fill_q + CW'(1);
            dcnt <= TS_W'(1);
            if (is_halt) halt_q <= 1'b1;
            if (state_q == S_ARMED && (match || is_halt)) begin
              trig_q    <= 1'b1;
              remaining <= pc_lat - CW'(1);
            end
            if (state_q == S_POST) remaining <= remaining - CW'(1);
          end else if (dcnt != '1) begin
            dcnt <= dcnt + TS_W'(1);
          end
        end
        S_DONE: if (xfer) begin
          if (rd_last) begin
            fill_q <= '0;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Randomised scenario bench for instr_trace_buffer; expected readout comes from a
// list-based model of the capture session.
module tb_instr_trace_buffer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned TS_W  = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic [PC_W-1:0] in_pc = '0;
  logic [31:0]     in_instr = '0;
  logic            arm = 1'b0;
  logic            clear = 1'b0;
  logic [31:0]     trig_mask = '0;
  logic [31:0]     trig_value = '0;
  logic [CW-1:0]   post_count = '0;
  logic [1:0]      state;
  logic            triggered;
  logic            halt_seen;
  logic [CW-1:0]   fill;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [PC_W-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic [TS_W-1:0] rd_delta;
  logic            rd_last;

  instr_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .arm(arm), .clear(clear), .trig_mask(trig_mask), .trig_value(trig_value),
    .post_count(post_count), .state(state), .triggered(triggered), .halt_seen(halt_seen),
    .fill(fill), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .rd_delta(rd_delta), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Session record: every retirement driven since the last arm.
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  longint      q_cy[$];
  logic [31:0] m_mask, m_value;
  int          m_post;
  // Expected readout and flags.
  logic [31:0] e_pc[$];
  logic [31:0] e_in[$];
  logic [15:0] e_dl[$];
  bit          e_done, e_halt, e_trig;
  // Observed readout.
  logic [31:0] o_pc[$];
  logic [31:0] o_in[$];
  logic [15:0] o_dl[$];
  bit          o_last[$];
  bit          o_timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] rnd_add();
    logic [31:0] r;
    r = $urandom();
    r[7:0] = 8'h13;
    return r;
  endfunction

  task automatic do_arm(input logic [31:0] mask, input logic [31:0] val, input int post,
                        input bit iv);
    trig_mask = mask; trig_value = val; post_count = CW'(post);
    m_mask = mask; m_value = val; m_post = post;
    arm = 1'b1; in_valid = iv; in_pc = 32'hDEAD_0000; in_instr = rnd_add();
    step();
    arm = 1'b0; in_valid = 1'b0;
    q_pc.delete(); q_in.delete(); q_cy.delete();
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1; in_pc = pc; in_instr = instr;
    q_pc.push_back(pc); q_in.push_back(instr); q_cy.push_back(cyc);
    step();
    in_valid = 1'b0;
  endtask

  // Model: find trigger, decide the stopping retirement, keep the last DEPTH captures.
  task automatic build_expect();
    int t, stop, plat, ncap, first;
    longint d;
    e_pc.delete(); e_in.delete(); e_dl.delete();
    plat = (m_post == 0) ? 1 : ((m_post > DEPTH) ? DEPTH : m_post);
    t = -1; stop = -1;
    for (int i = 0; i < q_in.size(); i++)
      if ((q_in[i] & m_mask) == (m_value & m_mask) || q_in[i][7:0] == 8'h09) begin
        t = i; break;
      end
    if (t >= 0) begin
      stop = t + plat - 1;
      if (q_in[t][7:0] == 8'h09) stop = t;
      else
        for (int j = t + 1; j < t + plat && j < q_in.size(); j++)
          if (q_in[j][7:0] == 8'h09) begin stop = j; break; end
    end
    e_done = (stop >= 0) && (stop < q_in.size());
    ncap   = e_done ? stop + 1 : q_in.size();
    e_trig = (t >= 0) && (t < ncap);
    e_halt = 1'b0;
    for (int i = 0; i < ncap; i++) if (q_in[i][7:0] == 8'h09) e_halt = 1'b1;
    first = (ncap > DEPTH) ? ncap - DEPTH : 0;
    for (int i = first; i < ncap; i++) begin
      d = (i == 0) ? 0 : q_cy[i] - q_cy[i-1];
      e_pc.push_back(q_pc[i]); e_in.push_back(q_in[i]);
      e_dl.push_back((d > 65535) ? 16'hFFFF : 16'(d));
    end
  endtask

  // Collect readout with random back-pressure; stops at rd_last or budget.
  task automatic drain(input int budget);
    bit done = 1'b0;
    o_pc.delete(); o_in.delete(); o_dl.delete(); o_last.delete();
    for (int c = 0; c < budget && !done; c++) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      if (rd_valid && rd_ready) begin
        o_pc.push_back(rd_pc); o_in.push_back(rd_instr);
        o_dl.push_back(rd_delta); o_last.push_back(rd_last);
        if (rd_last) done = 1'b1;
      end
      step();
    end
    rd_ready = 1'b0;
    o_timeout = !done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    checks++;
    if ({state, triggered, halt_seen, fill, rd_valid, rd_last} !== '0) begin
      errors++;
      $display("FAIL reset_flags got st=%0d tr=%0d hs=%0d fill=%0d v=%0d l=%0d want all 0",
               state, triggered, halt_seen, fill, rd_valid, rd_last);
    end
    checks++;
    if ({rd_pc, rd_instr, rd_delta} !== '0) begin
      errors++;
      $display("FAIL reset_data got pc=%h in=%h dl=%h want 0", rd_pc, rd_instr, rd_delta);
    end
  endtask

  task automatic test_halt_basic();
    do_arm(32'hFF, 32'h09, 1, 1'b0);
    for (int i = 0; i < 3; i++) retire(32'(4 * i), rnd_add());
    retire(32'h0C, 32'h0000_0009);
    build_expect();
    checks++;
    if ({state, fill, halt_seen, triggered} !== {2'd3, CW'(4), 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL halt_state got st=%0d fill=%0d hs=%0d tr=%0d want 3 4 1 1",
               state, fill, halt_seen, triggered);
    end
    drain(100);
    checks++;
    if (o_timeout || o_pc.size() != e_pc.size()) begin
      errors++;
      $display("FAIL halt_count got %0d timeout=%0d want %0d", o_pc.size(), o_timeout, e_pc.size());
    end
    for (int i = 0; i < e_pc.size() && i < o_pc.size(); i++) begin
      checks++;
      if ({o_pc[i], o_in[i], o_dl[i], o_last[i]} !== {e_pc[i], e_in[i], e_dl[i], (i == e_pc.size() - 1)}) begin
        errors++;
        $display("FAIL halt_entry%0d got pc=%h in=%h dl=%0d l=%0d want pc=%h in=%h dl=%0d",
                 i, o_pc[i], o_in[i], o_dl[i], o_last[i], e_pc[i], e_in[i], e_dl[i]);
      end
    end
    checks++;
    if ({state, fill} !== {2'd0, CW'(0)}) begin
      errors++;
      $display("FAIL halt_after got st=%0d fill=%0d want 0 0", state, fill);
    end
  endtask

  task automatic test_wrap();
    do_arm(32'hFF, 32'h11, 4, 1'b0);
    for (int i = 0; i < 40; i++) begin
      retire(32'(4 * i), rnd_add());
      idle($urandom_range(0, 2));
    end
    retire(32'(4 * 40), {24'h00ABC0 ^ 24'($urandom()), 8'h11});
    for (int i = 41; i < 50; i++) begin
      idle($urandom_range(0, 2));
      retire(32'(4 * i), rnd_add());
    end
    build_expect();
    checks++;
    if ({state, fill, triggered, halt_seen} !== {2'd3, CW'(16), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_state got st=%0d fill=%0d tr=%0d hs=%0d want 3 16 1 0",
               state, fill, triggered, halt_seen);
    end
    drain(200);
    checks++;
    if (o_timeout || o_pc.size() != e_pc.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d timeout=%0d want %0d", o_pc.size(), o_timeout, e_pc.size());
    end
    for (int i = 0; i < e_pc.size() && i < o_pc.size(); i++) begin
      checks++;
      if ({o_pc[i], o_in[i], o_dl[i], o_last[i]} !== {e_pc[i], e_in[i], e_dl[i], (i == e_pc.size() - 1)}) begin
        errors++;
        $display("FAIL wrap_entry%0d got pc=%h in=%h dl=%0d l=%0d want pc=%h in=%h dl=%0d",
                 i, o_pc[i], o_in[i], o_dl[i], o_last[i], e_pc[i], e_in[i], e_dl[i]);
      end
    end
  endtask

  task automatic test_post_zero();
    logic [31:0] pc;
    do_arm(32'h0, 32'h0, 0, 1'b1);
    pc = $urandom();
    retire(pc, rnd_add());
    build_expect();
    checks++;
    if ({state, fill, rd_valid, rd_last, rd_pc} !== {2'd3, CW'(1), 1'b1, 1'b1, pc}) begin
      errors++;
      $display("FAIL post0_state got st=%0d fill=%0d v=%0d l=%0d pc=%h want 3 1 1 1 %h",
               state, fill, rd_valid, rd_last, rd_pc, pc);
    end
    drain(50);
    checks++;
    if (o_timeout || o_pc.size() != 1 || {o_pc[0], o_in[0], o_dl[0]} !== {e_pc[0], e_in[0], e_dl[0]}) begin
      errors++;
      $display("FAIL post0_read got n=%0d timeout=%0d want 1 entry pc=%h", o_pc.size(), o_timeout, e_pc[0]);
    end
  endtask

  task automatic test_gaps();
    do_arm(32'hFF, 32'h11, 1, 1'b0);
    idle(2);
    retire(32'h100, rnd_add());
    idle(6);
    retire(32'h104, rnd_add());
    idle(69989);
    retire(32'h108, 32'h0000_0011);
    build_expect();
    drain(100);
    checks++;
    if (o_timeout || o_dl.size() != 3) begin
      errors++;
      $display("FAIL gaps_count got %0d timeout=%0d want 3", o_dl.size(), o_timeout);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_dl[i] !== e_dl[i]) begin
          errors++;
          $display("FAIL gaps_delta%0d got %0d want %0d", i, o_dl[i], e_dl[i]);
        end
      end
      checks++;
      if ({o_dl[0], o_dl[1], o_dl[2]} !== {16'd0, 16'd7, 16'hFFFF}) begin
        errors++;
        $display("FAIL gaps_fixed got %0d %0d %0d want 0 7 65535", o_dl[0], o_dl[1], o_dl[2]);
      end
    end
  endtask

  task automatic test_backpressure_clear();
    logic [31:0] pc0, in0;
    do_arm(32'h0, 32'h0, 3, 1'b0);
    for (int i = 0; i < 3; i++) retire(32'h200 + 32'(4 * i), rnd_add());
    build_expect();
    rd_ready = 1'b0;
    pc0 = rd_pc; in0 = rd_instr;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({rd_valid, rd_pc, rd_instr} !== {1'b1, e_pc[0], e_in[0]} || rd_pc !== pc0 || rd_instr !== in0) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%0d pc=%h want 1 pc=%h", i, rd_valid, rd_pc, e_pc[0]);
      end
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, rd_pc} !== {1'b1, e_pc[1]}) begin
      errors++;
      $display("FAIL hold_advance got v=%0d pc=%h want 1 %h", rd_valid, rd_pc, e_pc[1]);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({state, fill, rd_valid, triggered} !== {2'd0, CW'(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clear_mid got st=%0d fill=%0d v=%0d tr=%0d want 0 0 0 0",
               state, fill, rd_valid, triggered);
    end
  endtask

  task automatic test_arm_ignored_reset();
    do_arm(32'hFF, 32'h11, 4, 1'b0);
    retire(32'h300, 32'h0000_0511);
    arm = 1'b1; post_count = '0;
    step();
    arm = 1'b0;
    checks++;
    if ({state, fill} !== {2'd2, CW'(1)}) begin
      errors++;
      $display("FAIL arm_post got st=%0d fill=%0d want 2 1", state, fill);
    end
    for (int i = 1; i < 4; i++) retire(32'h300 + 32'(4 * i), rnd_add());
    arm = 1'b1;
    step();
    arm = 1'b0;
    build_expect();
    checks++;
    if ({state, fill, rd_pc} !== {2'd3, CW'(4), e_pc[0]}) begin
      errors++;
      $display("FAIL arm_done got st=%0d fill=%0d pc=%h want 3 4 %h", state, fill, rd_pc, e_pc[0]);
    end
    drain(100);
    checks++;
    if (o_timeout || o_pc.size() != 4 || o_pc[3] !== e_pc[3] || o_dl[3] !== e_dl[3]) begin
      errors++;
      $display("FAIL arm_read got n=%0d timeout=%0d want 4", o_pc.size(), o_timeout);
    end
    do_arm(32'hFF, 32'h11, 4, 1'b0);
    retire(32'h400, 32'h0000_0011);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL reset_pre got st=%0d want 2", state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({state, triggered, halt_seen, fill, rd_valid, rd_last, rd_pc, rd_instr, rd_delta} !== '0) begin
      errors++;
      $display("FAIL reset_post got st=%0d tr=%0d hs=%0d fill=%0d v=%0d want all 0",
               state, triggered, halt_seen, fill, rd_valid);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_halt_basic();
    test_wrap();
    test_post_zero();
    test_gaps();
    test_backpressure_clear();
    test_arm_ignored_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
